// File: rtl/control_incendio_multizona.sv
// Multi-zone fire-suppression controller: per-zone persistence FSM, timed water/CO2 discharge,
// alarm latch until ack. Optional saturating event counter enabled by CONTROL_INCENDIO_EVENTOS_EN.
module control_incendio_multizona #(
    parameter int N_ZONAS   = 4,
    parameter int ADC_W     = 4,
    parameter int T_ALTA    = 12,
    parameter int T_MEDIA   = 8,
    parameter int PERSIST   = 3,
    parameter int ACT_TICKS = 10,
    parameter int TICK_DIV  = 50000000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_ZONAS*ADC_W-1:0] temp,
    input  logic [N_ZONAS-1:0]       humo,
    input  logic [N_ZONAS-1:0]       elec,
    input  logic [N_ZONAS-1:0]       ack,
    input  logic                     reset_contador,
    output logic [N_ZONAS-1:0]       ejec_agua,
    output logic [N_ZONAS-1:0]       ejec_co2,
    output logic [N_ZONAS-1:0]       ventilador,
    output logic [N_ZONAS-1:0]       zona_alarma,
    output logic                     alarma,
    output logic [7:0]               eventos
);
    localparam int TW = $clog2(TICK_DIV);
    localparam int CW = $clog2(PERSIST + 1);
    localparam int AW = $clog2(ACT_TICKS + 1);
    localparam logic [TW-1:0]    TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [TW-1:0]    TICK_ONE  = TW'(1);
    localparam logic [CW-1:0]    CNT_ONE   = CW'(1);
    localparam logic [CW-1:0]    CNT_FIN   = CW'(PERSIST);
    localparam logic [AW-1:0]    TMR_INI   = AW'(ACT_TICKS);
    localparam logic [AW-1:0]    TMR_ONE   = AW'(1);
    localparam logic [ADC_W-1:0] T_ALTA_C  = ADC_W'(T_ALTA);
    localparam logic [ADC_W-1:0] T_MEDIA_C = ADC_W'(T_MEDIA);

    typedef enum logic [1:0] {IDLE, SOSPECHA, EXTINCION, ESPERA} estado_t;

    logic [TW-1:0]      tick_cnt_p1;
    logic               tick;
    logic [N_ZONAS-1:0] fuego, media, entra_p0;
    logic [N_ZONAS-1:0] agua_p0, co2_out_p0, vent_p0, zona_p0;
    estado_t            state_p1 [N_ZONAS];
    estado_t            state_p0 [N_ZONAS];
    logic [CW-1:0]      cnt_p1   [N_ZONAS];
    logic [CW-1:0]      cnt_p0   [N_ZONAS];
    logic [AW-1:0]      timer_p1 [N_ZONAS];
    logic [AW-1:0]      timer_p0 [N_ZONAS];
    logic [N_ZONAS-1:0] co2_p1, co2_p0;

    assign tick = (tick_cnt_p1 == TICK_LAST);

    always_comb begin
        fuego = '0;
        media = '0;
        for (int i = 0; i < N_ZONAS; i++) begin
            fuego[i] = humo[i] | (temp[i*ADC_W +: ADC_W] >= T_ALTA_C);
            media[i] = (temp[i*ADC_W +: ADC_W] >= T_MEDIA_C) & ~fuego[i];
        end
    end

    // stage p0: next-state decision per zone
    always_comb begin
        logic dispara;
        entra_p0   = '0;
        co2_p0     = co2_p1;
        agua_p0    = '0;
        co2_out_p0 = '0;
        vent_p0    = '0;
        zona_p0    = '0;
        for (int i = 0; i < N_ZONAS; i++) begin
            dispara     = 1'b0;
            state_p0[i] = state_p1[i];
            cnt_p0[i]   = cnt_p1[i];
            timer_p0[i] = timer_p1[i];
            case (state_p1[i])
                IDLE: begin
                    if (tick && fuego[i]) begin
                        cnt_p0[i] = CNT_ONE;
                        if (CNT_ONE == CNT_FIN) dispara = 1'b1;
                        else                    state_p0[i] = SOSPECHA;
                    end
                end
                SOSPECHA: begin
                    if (tick) begin
                        if (!fuego[i]) begin
                            state_p0[i] = IDLE;
                            cnt_p0[i]   = '0;
                        end else begin
                            cnt_p0[i] = cnt_p1[i] + CNT_ONE;
                            if (cnt_p0[i] == CNT_FIN) dispara = 1'b1;
                        end
                    end
                end
                EXTINCION: begin
                    // a zone that becomes energised mid-discharge switches to CO2 for good
                    co2_p0[i] = co2_p1[i] | elec[i];
                    if (tick) begin
                        if (timer_p1[i] == TMR_ONE) begin
                            timer_p0[i] = '0;
                            state_p0[i] = ESPERA;
                        end else begin
                            timer_p0[i] = timer_p1[i] - TMR_ONE;
                        end
                    end
                end
                ESPERA: begin
                    if (ack[i]) begin
                        if (fuego[i]) begin
                            dispara = 1'b1;
                        end else begin
                            state_p0[i] = IDLE;
                            cnt_p0[i]   = '0;
                        end
                    end
                end
                default: ;
            endcase
            if (dispara) begin
                state_p0[i] = EXTINCION;
                cnt_p0[i]   = '0;
                timer_p0[i] = TMR_INI;
                co2_p0[i]   = elec[i];
                entra_p0[i] = 1'b1;
            end
            agua_p0[i]    = (state_p0[i] == EXTINCION) & ~co2_p0[i];
            co2_out_p0[i] = (state_p0[i] == EXTINCION) &  co2_p0[i];
            zona_p0[i]    = (state_p0[i] == EXTINCION) | (state_p0[i] == ESPERA);
            vent_p0[i]    = media[i] & ((state_p0[i] == IDLE) | (state_p0[i] == SOSPECHA));
        end
    end

    // stage p1: registered state and outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt_p1 <= '0;
            co2_p1      <= '0;
            for (int i = 0; i < N_ZONAS; i++) begin
                state_p1[i] <= IDLE;
                cnt_p1[i]   <= '0;
                timer_p1[i] <= '0;
            end
            ejec_agua   <= '0;
            ejec_co2    <= '0;
            ventilador  <= '0;
            zona_alarma <= '0;
            alarma      <= 1'b0;
        end else begin
            tick_cnt_p1 <= tick ? '0 : tick_cnt_p1 + TICK_ONE;
            co2_p1      <= co2_p0;
            for (int i = 0; i < N_ZONAS; i++) begin
                state_p1[i] <= state_p0[i];
                cnt_p1[i]   <= cnt_p0[i];
                timer_p1[i] <= timer_p0[i];
            end
            ejec_agua   <= agua_p0;
            ejec_co2    <= co2_out_p0;
            ventilador  <= vent_p0;
            zona_alarma <= zona_p0;
            alarma      <= |zona_p0;
        end
    end

`ifdef CONTROL_INCENDIO_EVENTOS_EN
    logic [7:0] eventos_p1;
    logic [8:0] suma_p0;

    function automatic logic [7:0] satura(input logic [8:0] v);
        return v[8] ? 8'hFF : v[7:0];
    endfunction

    always_comb begin
        suma_p0 = {1'b0, eventos_p1};
        for (int i = 0; i < N_ZONAS; i++) suma_p0 = suma_p0 + {8'd0, entra_p0[i]};
    end

    always_ff @(posedge clk) begin
        if (reset || reset_contador) eventos_p1 <= '0;
        else                         eventos_p1 <= satura(suma_p0);
    end

    assign eventos = eventos_p1;
`else
    logic unused_contador;
    assign unused_contador = reset_contador | (|entra_p0);
    assign eventos = 8'd0;
`endif
endmodule

// File: doc/control_incendio_multizona.md
# control_incendio_multizona

Parametrised multi-zone fire-suppression controller, the successor of the single-zone control chain (ADC decode, state machine, actuator output). It classifies N zones from per-zone temperature codes, smoke and electrical-presence inputs, and confirms fire by persistence over divided-clock ticks. It drives a timed water or CO2 discharge per zone, latches each zone's alarm until an operator acknowledge, and keeps a global event counter. It sits between the sensor front end and the actuator/display drivers.

## Interface
- N_ZONAS, 4: number of independent zones.
- ADC_W, 4: width of each temperature code.
- T_ALTA, 12: code at or above which a zone reads high temperature.
- T_MEDIA, 8: code at or above which a zone reads medium temperature. Requires T_MEDIA < T_ALTA.
- PERSIST, 3: consecutive ticks of fire needed to trigger discharge. Must be ≥1.
- ACT_TICKS, 10: discharge duration in ticks. Must be ≥1.
- TICK_DIV, 50000000: clk cycles per tick. Must be ≥2.
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- temp  in  N_ZONAS*ADC_W  temperature codes; zone i is bits [i*ADC_W +: ADC_W], unsigned.
- humo  in  N_ZONAS  smoke detected, per zone.
- elec  in  N_ZONAS  zone is energised, per zone.
- ack  in  N_ZONAS  operator acknowledge, per zone; level-sampled each clk.
- reset_contador  in  1  clears the event counter.
- ejec_agua  out  N_ZONAS  water valve, per zone.
- ejec_co2  out  N_ZONAS  CO2 valve, per zone.
- ventilador  out  N_ZONAS  ventilation on medium temperature.
- zona_alarma  out  N_ZONAS  zone is in EXTINCION or ESPERA.
- alarma  out  1  OR of zona_alarma.
- eventos  out  8  saturating count of discharges.

## Operation
- Tick: a counter runs 0..TICK_DIV-1. tick=1 for one clk when the counter equals TICK_DIV-1. The first tick comes TICK_DIV cycles after reset deasserts.
- Per-zone classification, evaluated every clk:
  - fuego = humo[i] | (temp_i ≥ T_ALTA).
  - media = (temp_i ≥ T_MEDIA) & !fuego.
- Per-zone FSM, with states IDLE, SOSPECHA, EXTINCION, ESPERA. State changes happen only on tick cycles, except ack handling, which is evaluated every clk.
  - IDLE, on tick with fuego: cnt=1. Go to EXTINCION if PERSIST==1, otherwise go to SOSPECHA.
  - SOSPECHA, on tick:
    - !fuego: go to IDLE, cnt=0.
    - fuego: cnt+1. If cnt+1 == PERSIST, go to EXTINCION.
  - EXTINCION, on entry:
    - timer=ACT_TICKS.
    - co2_lat = elec[i].
    - Increment the event count.
  - EXTINCION, each tick: decrement timer. When timer reaches 0, go to ESPERA.
  - ESPERA: hold until ack[i]=1.
    - ack with !fuego: go to IDLE.
    - ack with fuego: go to EXTINCION (re-entry, counted as a new event).
  - ack in any state other than ESPERA has no effect.
- Agent selection:
  - ejec_co2 = EXTINCION & co2_lat.
  - ejec_agua = EXTINCION & !co2_lat.
  - If elec[i] rises while water is discharging, co2_lat is set on the next clk and water stops; water is never driven with elec high for more than 1 clk.
  - co2_lat is never cleared during a discharge.
- ventilador[i] = media and state in {IDLE, SOSPECHA}.
- eventos:
  - Adds the number of zones entering EXTINCION in the same cycle (popcount).
  - Saturates at 255.
  - reset_contador clears it; clear wins over a simultaneous increment.

## Timing
- All outputs are registered. Reset value of every output, and of all states, counters and latches, is 0, one edge after reset is sampled high.
- Reset asserted mid-discharge: valves are 0 after the next edge, the FSM is in IDLE, and the tick counter restarts at 0.
- State transitions and the resulting outputs are visible 1 clk after the deciding tick or ack cycle.
- Discharge length is exactly ACT_TICKS*TICK_DIV clk cycles.
- Fire detection latency from fuego becoming stable: (PERSIST-1) full tick periods, plus the time to the first tick, plus 1 clk.
- ventilador has 1 clk latency from temp.

## Configuration
- CONTROL_INCENDIO_EVENTOS_EN
  - Defined: the event counter is present as described.
  - Undefined: counter logic is removed, eventos is tied to 8'd0, and reset_contador is ignored. The port list is unchanged.

## Test plan
Bench settings: N_ZONAS=2, ADC_W=4, T_ALTA=12, T_MEDIA=8, PERSIST=3, ACT_TICKS=4, TICK_DIV=4.
- Zone0 temp=13, elec=0 held → ejec_agua[0]=1 one clk after the 3rd tick; stays 1 for 16 clks; then zona_alarma[0]=1 and alarma=1 held; ack[0]=1 with temp=5 → all zone0 outputs 0 next clk; eventos=1.
- Zone1 humo pulse lasting 2 ticks only → returns to IDLE; no valve; eventos=0.
- Zone0 temp=9 → ventilador[0]=1 after 1 clk; no alarm; temp=12 → ventilador[0]=0.
- Zone0 elec=1 at trigger → ejec_co2[0]=1 and ejec_agua[0]=0. Separate run: elec rises mid water discharge → water off and CO2 on within 1 clk.
- Both zones trigger on the same tick → eventos increments by 2. Also check saturation at 255, and reset_contador coincident with an increment → 0.
- Reset asserted mid-discharge → all outputs 0 after 1 edge; re-trigger needs a full PERSIST again. ESPERA with ack while fire is still present → new 16-clk discharge.
